// File: rtl/sccb_responder.sv
// SCCB slave: filters SCL/SDA, decodes START/STOP/bytes, emits register write strobes and read requests.
// Read path compiled in only when SCCB_RESPONDER_READ_EN is defined; otherwise read IDs are ignored.
module sccb_responder #(
  parameter logic [6:0] DEV_ID   = 7'h30,
  parameter int         FILT_LEN = 3
) (
  input  logic       iclk,
  input  logic       irst_n,
  input  logic       iscl,
  input  logic       isda,
  output logic       osda_oe,
  output logic       owr_stb,
  output logic [7:0] owr_addr,
  output logic [7:0] owr_data,
  output logic       ord_stb,
  output logic [7:0] ord_addr,
  input  logic [7:0] irdata,
  output logic       obusy
);

  localparam int CW = $clog2(FILT_LEN + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_ID, S_ID_ACK, S_SUB, S_SUB_ACK,
    S_WDATA, S_WDATA_ACK, S_RDATA, S_RDATA_ACK, S_IGNORE
  } state_t;

  // Index 1 = SCL, index 0 = SDA; everything resets high so a reset release never looks like a START.
  logic [1:0]         sync1_q, sync2_q, filt_q, prev_q;
  logic [1:0][CW-1:0] fcnt_q;

  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      sync1_q <= '1;
      sync2_q <= '1;
      filt_q  <= '1;
      prev_q  <= '1;
      fcnt_q  <= '0;
    end else begin
      sync1_q <= {iscl, isda};
      sync2_q <= sync1_q;
      prev_q  <= filt_q;
      for (int i = 0; i < 2; i++) begin
        if (sync2_q[i] == filt_q[i]) begin
          fcnt_q[i] <= '0;
        end else if (fcnt_q[i] == CW'(FILT_LEN - 1)) begin
          filt_q[i] <= sync2_q[i];
          fcnt_q[i] <= '0;
        end else begin
          fcnt_q[i] <= fcnt_q[i] + 1'b1;
        end
      end
    end
  end

  logic scl_f, sda_f, scl_rise, scl_fall, start_det, stop_det;
  assign scl_f     = filt_q[1];
  assign sda_f     = filt_q[0];
  assign scl_rise  = scl_f & ~prev_q[1];
  assign scl_fall  = ~scl_f & prev_q[1];
  assign start_det = scl_f & prev_q[1] & prev_q[0] & ~sda_f;
  assign stop_det  = scl_f & prev_q[1] & ~prev_q[0] & sda_f;

  state_t     state_q;
  logic [2:0] cnt_q;
  logic       phase_q;
  logic [6:0] shift_q;
  logic [7:0] addr_q;
  logic       oe_q;
  logic       wr_stb_q;
  logic [7:0] wr_addr_q, wr_data_q;
  logic       busy_q;
  logic [7:0] byte_d;
  logic       id_wr_d;

  assign byte_d  = {shift_q, sda_f};
  assign id_wr_d = (byte_d == {DEV_ID, 1'b0});

`ifdef SCCB_RESPONDER_READ_EN
  logic       rw_q;
  logic [7:0] rd_sh_q;
  logic       rd_stb_q;
  logic [7:0] rd_addr_q;
  logic       id_rd_d;
  assign id_rd_d = (byte_d == {DEV_ID, 1'b1});
`endif

  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      phase_q   <= 1'b0;
      shift_q   <= '0;
      addr_q    <= '0;
      oe_q      <= 1'b0;
      wr_stb_q  <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      busy_q    <= 1'b0;
`ifdef SCCB_RESPONDER_READ_EN
      rw_q      <= 1'b0;
      rd_sh_q   <= '0;
      rd_stb_q  <= 1'b0;
      rd_addr_q <= '0;
`endif
    end else begin
      wr_stb_q <= 1'b0;
`ifdef SCCB_RESPONDER_READ_EN
      rd_stb_q <= 1'b0;
      if (rd_stb_q) rd_sh_q <= irdata;
`endif
      if (stop_det) begin
        state_q <= S_IDLE;
        oe_q    <= 1'b0;
        busy_q  <= 1'b0;
        phase_q <= 1'b0;
      end else if (start_det) begin
        state_q <= S_ID;
        cnt_q   <= '0;
        oe_q    <= 1'b0;
        busy_q  <= 1'b1;
        phase_q <= 1'b0;
      end else begin
        case (state_q)
          S_ID, S_SUB, S_WDATA: begin
            if (scl_rise) begin
              shift_q <= byte_d[6:0];
              cnt_q   <= cnt_q + 3'd1;
              if (cnt_q == 3'd7) begin
                phase_q <= 1'b0;
                if (state_q == S_ID) begin
                  if (id_wr_d) begin
                    state_q <= S_ID_ACK;
`ifdef SCCB_RESPONDER_READ_EN
                    rw_q    <= 1'b0;
                  end else if (id_rd_d) begin
                    state_q <= S_ID_ACK;
                    rw_q    <= 1'b1;
`endif
                  end else begin
                    state_q <= S_IGNORE;
                  end
                end else if (state_q == S_SUB) begin
                  addr_q  <= byte_d;
                  state_q <= S_SUB_ACK;
                end else begin
                  wr_stb_q  <= 1'b1;
                  wr_addr_q <= addr_q;
                  wr_data_q <= byte_d;
                  addr_q    <= addr_q + 8'd1;
                  state_q   <= S_WDATA_ACK;
                end
              end
            end
          end
          // phase_q: 0 = waiting for the fall that starts ACK drive, 1 = waiting for the fall that ends it
          S_ID_ACK, S_SUB_ACK, S_WDATA_ACK: begin
            if (scl_fall) begin
              if (!phase_q) begin
                oe_q    <= 1'b1;
                phase_q <= 1'b1;
`ifdef SCCB_RESPONDER_READ_EN
                if (state_q == S_ID_ACK && rw_q) begin
                  rd_stb_q  <= 1'b1;
                  rd_addr_q <= addr_q;
                end
`endif
              end else begin
                oe_q    <= 1'b0;
                phase_q <= 1'b0;
                cnt_q   <= '0;
                if (state_q == S_ID_ACK) state_q <= S_SUB;
                else                     state_q <= S_WDATA;
`ifdef SCCB_RESPONDER_READ_EN
                if (state_q == S_ID_ACK && rw_q) begin
                  oe_q    <= ~rd_sh_q[7];
                  rd_sh_q <= {rd_sh_q[6:0], 1'b0};
                  state_q <= S_RDATA;
                end
`endif
              end
            end
          end
`ifdef SCCB_RESPONDER_READ_EN
          S_RDATA: begin
            if (scl_rise) begin
              cnt_q <= cnt_q + 3'd1;
              if (cnt_q == 3'd7) begin
                state_q <= S_RDATA_ACK;
                phase_q <= 1'b0;
              end
            end else if (scl_fall) begin
              oe_q    <= ~rd_sh_q[7];
              rd_sh_q <= {rd_sh_q[6:0], 1'b0};
            end
          end
          S_RDATA_ACK: begin
            if (scl_fall && !phase_q) begin
              oe_q    <= 1'b0;
              phase_q <= 1'b1;
            end else if (scl_rise && phase_q) begin
              phase_q <= 1'b0;
              if (!sda_f) begin
                addr_q    <= addr_q + 8'd1;
                rd_stb_q  <= 1'b1;
                rd_addr_q <= addr_q + 8'd1;
                cnt_q     <= '0;
                state_q   <= S_RDATA;
              end else begin
                state_q <= S_IGNORE;
              end
            end
          end
`endif
          S_IDLE, S_IGNORE: ;
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign osda_oe  = oe_q;
  assign owr_stb  = wr_stb_q;
  assign owr_addr = wr_addr_q;
  assign owr_data = wr_data_q;
  assign obusy    = busy_q;

`ifdef SCCB_RESPONDER_READ_EN
  assign ord_stb  = rd_stb_q;
  assign ord_addr = rd_addr_q;
`else
  assign ord_stb  = 1'b0;
  assign ord_addr = 8'h00;
  logic unused_rdata;
  assign unused_rdata = ^irdata;
`endif

endmodule
